// File: rtl/mc_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
//  Shared definitions for the RV32I multi-cycle control sequencer:
//   - state codes (FETCH=0 .. HALT) and the state enum built from them
//   - RV32I major opcode constants
//   - encodings of alu_src_a, alu_src_b, alu_op_sel and result_src
//   - instruction class enum produced by mc_opcode_decode
//   - the Moore output bundle and the function that decodes it from a state
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // State codes, also visible on state_dbg
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXEC_R    = 4'd2;
  localparam logic [3:0] S_EXEC_I    = 4'd3;
  localparam logic [3:0] S_EXEC_U    = 4'd4;
  localparam logic [3:0] S_WB_ALU    = 4'd5;
  localparam logic [3:0] S_MEM_ADDR  = 4'd6;
  localparam logic [3:0] S_MEM_RD    = 4'd7;
  localparam logic [3:0] S_WB_MEM    = 4'd8;
  localparam logic [3:0] S_MEM_WR    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_EXEC_JALR = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_HALT      = 4'd13;

  typedef enum logic [3:0] {
    ST_FETCH     = S_FETCH,
    ST_DECODE    = S_DECODE,
    ST_EXEC_R    = S_EXEC_R,
    ST_EXEC_I    = S_EXEC_I,
    ST_EXEC_U    = S_EXEC_U,
    ST_WB_ALU    = S_WB_ALU,
    ST_MEM_ADDR  = S_MEM_ADDR,
    ST_MEM_RD    = S_MEM_RD,
    ST_WB_MEM    = S_WB_MEM,
    ST_MEM_WR    = S_MEM_WR,
    ST_BRANCH    = S_BRANCH,
    ST_EXEC_JALR = S_EXEC_JALR,
    ST_JUMP      = S_JUMP,
    ST_HALT      = S_HALT
  } state_t;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Datapath mux encodings
  localparam logic [1:0] ASA_PC     = 2'b00;
  localparam logic [1:0] ASA_RS1    = 2'b01;
  localparam logic [1:0] ASA_ZERO   = 2'b10;
  localparam logic [1:0] ASB_RS2    = 2'b00;
  localparam logic [1:0] ASB_IMM    = 2'b01;
  localparam logic [1:0] ASB_FOUR   = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_CMP    = 2'b01;
  localparam logic [1:0] ALU_DEC    = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC     = 2'b10;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_NONE
  } instr_class_t;

  // Outputs that depend only on the state (plus the class latched with it)
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_write;
    logic       pc_write;
    logic       retire;
    logic       halted;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_sel;
    logic [1:0] result_src;
  } moore_t;

  // The class argument only matters for EXEC_U, where LUI and AUIPC differ
  // in the ALU A source.
  function automatic moore_t moore_outputs(state_t s, instr_class_t cls);
    moore_t o;
    o = '0;
    case (s)
      ST_FETCH: begin
        o.mem_req   = 1'b1;
        o.alu_src_a = ASA_PC;
        o.alu_src_b = ASB_FOUR;
        o.alu_op_sel = ALU_ADD;
      end
      ST_DECODE: begin
        o.alu_src_a = ASA_PC;
        o.alu_src_b = ASB_IMM;
        o.alu_op_sel = ALU_ADD;
      end
      ST_EXEC_R: begin
        o.alu_src_a = ASA_RS1;
        o.alu_src_b = ASB_RS2;
        o.alu_op_sel = ALU_DEC;
      end
      ST_EXEC_I: begin
        o.alu_src_a = ASA_RS1;
        o.alu_src_b = ASB_IMM;
        o.alu_op_sel = ALU_DEC;
      end
      ST_EXEC_U: begin
        o.alu_src_a = (cls == CLS_LUI) ? ASA_ZERO : ASA_PC;
        o.alu_src_b = ASB_IMM;
        o.alu_op_sel = ALU_ADD;
      end
      ST_WB_ALU: begin
        o.reg_write  = 1'b1;
        o.result_src = RES_ALUOUT;
        o.retire     = 1'b1;
      end
      ST_MEM_ADDR, ST_EXEC_JALR: begin
        o.alu_src_a = ASA_RS1;
        o.alu_src_b = ASB_IMM;
        o.alu_op_sel = ALU_ADD;
      end
      ST_MEM_RD: begin
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
      end
      ST_WB_MEM: begin
        o.reg_write  = 1'b1;
        o.result_src = RES_MEM;
        o.retire     = 1'b1;
      end
      ST_MEM_WR: begin
        o.mem_req = 1'b1;
        o.mem_we  = 1'b1;
        o.iord    = 1'b1;
      end
      ST_BRANCH: begin
        o.alu_src_a = ASA_RS1;
        o.alu_src_b = ASB_RS2;
        o.alu_op_sel = ALU_CMP;
        o.retire    = 1'b1;
      end
      ST_JUMP: begin
        o.reg_write  = 1'b1;
        o.result_src = RES_PC;
        o.pc_write   = 1'b1;
        o.retire     = 1'b1;
      end
      ST_HALT: o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_if
//  Control bundle between the sequencer and the RV32I datapath.
//   master (sequencer): in  opcode, branch_taken, mem_ready
//                       out mem_req, mem_we, iord, ir_write, pc_write,
//                           reg_write, alu_src_a, alu_src_b, alu_op_sel,
//                           result_src, instr_retired
//   slave  (datapath):  the same signals with directions reversed
// ---------------------------------------------------------------------------
interface mc_ctrl_if;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op_sel;
  logic [1:0] result_src;
  logic       instr_retired;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op_sel, result_src, instr_retired
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op_sel, result_src, instr_retired
  );
endinterface

// File: rtl/mc_ctrl_fsm_opcode_decode.sv
// ---------------------------------------------------------------------------
// mc_opcode_decode
//  Combinational RV32I opcode classifier used for the DECODE branch.
//   opcode  in  7  IR[6:0]
//   cls     out    instruction class
//   illegal out 1  opcode is not an RV32I major opcode
// ---------------------------------------------------------------------------
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IMM:    cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_SYSTEM: cls = CLS_SYSTEM;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//  Multi-cycle sequencer for the RV32I datapath. Walks each instruction
//  through FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, halts on
//  ECALL/EBREAK or an unknown opcode.
//  Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-low
//   bus          mc_ctrl_if.master  datapath strobes/selects + handshake
//   halted       out  sticky, set on entry to HALT
//   illegal      out  sticky, halt caused by an unknown opcode
//   state_dbg    out  current state code
//   cycle_cnt    out  cycles spent outside reset and HALT
//   instret_cnt  out  retired instructions
//  Build option: MC_PERF_CNT_EN enables the two counters; without it they
//  read as 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  mc_ctrl_if.master          bus,
  output logic               halted,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  state_t       state;
  state_t       next_state;
  moore_t       outs_q;
  logic         illegal_q;
  instr_class_t cls;
  logic         dec_illegal;
  logic         retire;

  mc_opcode_decode u_decode (
    .opcode  (bus.opcode),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  // Next-state selection; DECODE and MEM_ADDR branch on the opcode class.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:     next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (cls)
          CLS_R:                next_state = ST_EXEC_R;
          CLS_I:                next_state = ST_EXEC_I;
          CLS_LOAD, CLS_STORE:  next_state = ST_MEM_ADDR;
          CLS_BRANCH:           next_state = ST_BRANCH;
          CLS_JAL:              next_state = ST_JUMP;
          CLS_JALR:             next_state = ST_EXEC_JALR;
          CLS_LUI, CLS_AUIPC:   next_state = ST_EXEC_U;
          default:              next_state = ST_HALT;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I, ST_EXEC_U: next_state = ST_WB_ALU;
      ST_MEM_ADDR:  next_state = (cls == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:    next_state = bus.mem_ready ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR:    next_state = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_EXEC_JALR: next_state = ST_JUMP;
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: next_state = ST_FETCH;
      ST_HALT:      next_state = ST_HALT;
      default:      next_state = ST_FETCH;
    endcase
  end

  // State register with the Moore outputs of the state being entered
  // registered alongside it, so they come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_FETCH;
      outs_q    <= moore_outputs(ST_FETCH, CLS_NONE);
      illegal_q <= 1'b0;
    end else begin
      state  <= next_state;
      outs_q <= moore_outputs(next_state, cls);
      if (state == ST_DECODE && dec_illegal)
        illegal_q <= 1'b1;
    end
  end

  // Every output is masked by rst so an access in flight is abandoned in
  // the very cycle reset is asserted, ahead of the synchronous state reset.
  // The store retires on the handshake cycle itself, hence the qualifier.
  assign retire = rst & (outs_q.retire | (state == ST_MEM_WR && bus.mem_ready));

  assign bus.mem_req       = rst & outs_q.mem_req;
  assign bus.mem_we        = rst & outs_q.mem_we;
  assign bus.iord          = rst & outs_q.iord;
  assign bus.ir_write      = rst & (state == ST_FETCH) & bus.mem_ready;
  assign bus.pc_write      = rst & (outs_q.pc_write
                                    | ((state == ST_FETCH) & bus.mem_ready)
                                    | ((state == ST_BRANCH) & bus.branch_taken));
  assign bus.reg_write     = rst & outs_q.reg_write;
  assign bus.alu_src_a     = rst ? outs_q.alu_src_a  : 2'b00;
  assign bus.alu_src_b     = rst ? outs_q.alu_src_b  : 2'b00;
  assign bus.alu_op_sel    = rst ? outs_q.alu_op_sel : 2'b00;
  assign bus.result_src    = rst ? outs_q.result_src : 2'b00;
  assign bus.instr_retired = retire;

  assign halted    = rst & outs_q.halted;
  assign illegal   = rst & illegal_q;
  assign state_dbg = rst ? STATE_W'(state) : '0;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // Free-running performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != ST_HALT)
        cycle_q <= cycle_q + CNT_W'(1);
      if (retire)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = rst ? cycle_q   : '0;
  assign instret_cnt = rst ? instret_q : '0;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//  Directed bench for mc_ctrl_fsm. A table of per-cycle vectors
//  {rst, opcode, branch_taken, mem_ready} -> {state, strobes, selects} is
//  applied one cycle at a time, followed by hand-written sequences for the
//  illegal-opcode halt and (with MC_PERF_CNT_EN) the perf counters.
//  Strobe bit order: {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
//  instr_retired, halted, illegal}. Select order: {a, b, op, result}.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUI = 7'b0010111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  typedef struct packed {
    logic       r;
    logic [6:0] opc;
    logic       bt;
    logic       rdy;
    logic [3:0] st;
    logic [8:0] stb;
    logic [7:0] sel;
    logic [7:0] mask;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        halted;
  logic        illegal;
  logic [3:0]  state_dbg;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  int          compared;
  int          mismatched;
  vec_t        vecs[$];

  mc_ctrl_if bus();

  mc_ctrl_fsm #(.CNT_W(32), .STATE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halted      (halted),
    .illegal     (illegal),
    .state_dbg   (state_dbg),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic [6:0] opc, logic bt, logic rdy,
                              logic [3:0] st, logic [8:0] stb,
                              logic [7:0] sel, logic [7:0] mask);
    vec_t v;
    v.r = r; v.opc = opc; v.bt = bt; v.rdy = rdy;
    v.st = st; v.stb = stb; v.sel = sel; v.mask = mask;
    return v;
  endfunction

  // Drive the inputs of one cycle just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst              = v.r;
    bus.opcode       = v.opc;
    bus.branch_taken = v.bt;
    bus.mem_ready    = v.rdy;
  endtask

  // Compare state+strobes, and the selects under the vector's mask.
  task automatic checkOutput(input vec_t v, input int idx);
    logic [12:0] act;
    logic [7:0]  sel;
    @(negedge clk);
    act = {state_dbg, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write,
           bus.pc_write, bus.reg_write, bus.instr_retired, halted, illegal};
    sel = {bus.alu_src_a, bus.alu_src_b, bus.alu_op_sel, bus.result_src};
    compared++;
    if (act !== {v.st, v.stb}) begin
      mismatched++;
      $display("[TB] FAIL vec%0d state/strobes: got st=%0d stb=%b, want st=%0d stb=%b",
               idx, act[12:9], act[8:0], v.st, v.stb);
    end
    if (v.mask != 8'h00) begin
      compared++;
      if ((sel & v.mask) !== (v.sel & v.mask)) begin
        mismatched++;
        $display("[TB] FAIL vec%0d selects: got %b, want %b (mask %b)",
                 idx, sel & v.mask, v.sel & v.mask, v.mask);
      end
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.opcode = 7'd0;
    bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b0;
    compared = 0;
    mismatched = 0;

    // reset held 3 cycles with mem_ready=1: everything reads 0
    repeat (3) vecs.push_back(mk(0, OPC_R, 0, 1, 0, 9'b000000000, 8'h00, 8'hFF));
    // R-type: FETCH, DECODE, EXEC_R, WB_ALU
    vecs.push_back(mk(1, OPC_R, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_R, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_R, 0, 1, 2, 9'b000000000, 8'b01_00_10_00, 8'hFC));
    vecs.push_back(mk(1, OPC_R, 0, 1, 5, 9'b000001100, 8'b00_00_00_00, 8'h03));
    // I-type
    vecs.push_back(mk(1, OPC_I, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_I, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_I, 0, 1, 3, 9'b000000000, 8'b01_01_10_00, 8'hFC));
    vecs.push_back(mk(1, OPC_I, 0, 1, 5, 9'b000001100, 8'b00_00_00_00, 8'h03));
    // LUI: A=zero
    vecs.push_back(mk(1, OPC_LUI, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_LUI, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_LUI, 0, 1, 4, 9'b000000000, 8'b10_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_LUI, 0, 1, 5, 9'b000001100, 8'b00_00_00_00, 8'h03));
    // AUIPC: A=PC
    vecs.push_back(mk(1, OPC_AUI, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_AUI, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_AUI, 0, 1, 4, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_AUI, 0, 1, 5, 9'b000001100, 8'b00_00_00_00, 8'h03));
    // load, mem_ready low for 2 cycles in MEM_RD: 7 cycles
    vecs.push_back(mk(1, OPC_LD, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_LD, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_LD, 0, 1, 6, 9'b000000000, 8'b01_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_LD, 0, 0, 7, 9'b101000000, 8'h00, 8'h00));
    vecs.push_back(mk(1, OPC_LD, 0, 0, 7, 9'b101000000, 8'h00, 8'h00));
    vecs.push_back(mk(1, OPC_LD, 0, 1, 7, 9'b101000000, 8'h00, 8'h00));
    vecs.push_back(mk(1, OPC_LD, 0, 1, 8, 9'b000001100, 8'b00_00_00_01, 8'h03));
    // store, no wait: retires in MEM_WR
    vecs.push_back(mk(1, OPC_ST, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_ST, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_ST, 0, 1, 6, 9'b000000000, 8'b01_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_ST, 0, 1, 9, 9'b111000100, 8'h00, 8'h00));
    // branch taken
    vecs.push_back(mk(1, OPC_BR, 1, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_BR, 1, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_BR, 1, 1, 10, 9'b000010100, 8'b01_00_01_00, 8'hFC));
    // branch not taken, one FETCH wait first
    vecs.push_back(mk(1, OPC_BR, 0, 0, 0, 9'b100000000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_BR, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_BR, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_BR, 0, 1, 10, 9'b000000100, 8'b01_00_01_00, 8'hFC));
    // JAL: 3 cycles, rd<=PC
    vecs.push_back(mk(1, OPC_JAL, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_JAL, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_JAL, 0, 1, 12, 9'b000011100, 8'b00_00_00_10, 8'h03));
    // JALR: 4 cycles
    vecs.push_back(mk(1, OPC_JR, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_JR, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_JR, 0, 1, 11, 9'b000000000, 8'b01_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_JR, 0, 1, 12, 9'b000011100, 8'b00_00_00_10, 8'h03));
    // store stalled, then reset during the wait abandons it
    vecs.push_back(mk(1, OPC_ST, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_ST, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_ST, 0, 1, 6, 9'b000000000, 8'b01_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_ST, 0, 0, 9, 9'b111000000, 8'h00, 8'h00));
    vecs.push_back(mk(0, OPC_ST, 1, 1, 0, 9'b000000000, 8'h00, 8'hFF));
    vecs.push_back(mk(1, OPC_SYS, 0, 0, 0, 9'b100000000, 8'b00_10_00_00, 8'hFC));
    // ECALL: HALT with halted=1, illegal=0
    vecs.push_back(mk(1, OPC_SYS, 0, 1, 0, 9'b100110000, 8'b00_10_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_SYS, 0, 1, 1, 9'b000000000, 8'b00_01_00_00, 8'hFC));
    vecs.push_back(mk(1, OPC_SYS, 0, 1, 13, 9'b000000010, 8'h00, 8'h00));
    vecs.push_back(mk(1, OPC_SYS, 1, 1, 13, 9'b000000010, 8'h00, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Illegal opcode right after reset: halts, strobes stay 0 for 20 cycles
    applyStimulus(mk(0, OPC_BAD, 0, 1, 0, 9'b000000000, 8'h00, 8'h00));
    checkOutput(mk(0, OPC_BAD, 0, 1, 0, 9'b000000000, 8'h00, 8'hFF), 1000);
    applyStimulus(mk(1, OPC_BAD, 0, 1, 0, 9'b100110000, 8'h00, 8'h00));
    checkOutput(mk(1, OPC_BAD, 0, 1, 0, 9'b100110000, 8'h00, 8'h00), 1001);
    applyStimulus(mk(1, OPC_BAD, 0, 1, 1, 9'b000000000, 8'h00, 8'h00));
    checkOutput(mk(1, OPC_BAD, 0, 1, 1, 9'b000000000, 8'h00, 8'h00), 1002);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mk(1, OPC_BAD, 1, 1, 13, 9'b000000011, 8'h00, 8'h00));
      checkOutput(mk(1, OPC_BAD, 1, 1, 13, 9'b000000011, 8'h00, 8'h00), 1100 + i);
    end
    checkCount("instret_after_illegal", instret_cnt, 32'd0);
`ifdef MC_PERF_CNT_EN
    // only FETCH and DECODE count; HALT freezes the cycle counter
    checkCount("cycle_after_illegal", cycle_cnt, 32'd2);

    // 10 back-to-back R-type instructions: 40 cycles
    applyStimulus(mk(0, OPC_R, 0, 1, 0, 9'b0, 8'h00, 8'h00));
    repeat (41) applyStimulus(mk(1, OPC_R, 0, 1, 0, 9'b0, 8'h00, 8'h00));
    @(negedge clk);
    checkCount("instret_10_rtype", instret_cnt, 32'd10);
    checkCount("cycle_10_rtype", cycle_cnt, 32'd40);
`else
    checkCount("cycle_cnt_tied", cycle_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
